// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and AXI constants for the two-requester ROM read arbiter.
// Response codes and default widths mirror AXI_define.svh when it has not already been included.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_IDS_BITS 8
`define AXI_LEN_BITS 4
`define AXI_RESP_OKAY 2'b00
`define AXI_RESP_DECERR 2'b11
`endif

package rom_arb_pkg;

  localparam int ROM_AW_DEF = 12;
  localparam int IDW_DEF    = `AXI_IDS_BITS;
  localparam int LENW_DEF   = `AXI_LEN_BITS;

  localparam logic [1:0] RESP_OKAY   = `AXI_RESP_OKAY;
  localparam logic [1:0] RESP_DECERR = `AXI_RESP_DECERR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } owner_t;

  function automatic owner_t flip_owner(input owner_t o);
    return (o == S0) ? S1 : S0;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Both AXI read slave ports plus the ROM macro pins, bundled for the arbiter.
// slave = arbiter side; master = requesters and ROM model side.
interface rom_read_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int ROM_AW = ROM_AW_DEF,
  parameter int IDW    = IDW_DEF,
  parameter int LENW   = LENW_DEF
);

  logic [IDW-1:0]    ARID_S0,    ARID_S1;
  logic [31:0]       ARADDR_S0,  ARADDR_S1;
  logic [LENW-1:0]   ARLEN_S0,   ARLEN_S1;
  logic [2:0]        ARSIZE_S0,  ARSIZE_S1;
  logic [1:0]        ARBURST_S0, ARBURST_S1;
  logic              ARVALID_S0, ARVALID_S1;
  logic              ARREADY_S0, ARREADY_S1;

  logic [IDW-1:0]    RID_S0,     RID_S1;
  logic [31:0]       RDATA_S0,   RDATA_S1;
  logic [1:0]        RRESP_S0,   RRESP_S1;
  logic              RLAST_S0,   RLAST_S1;
  logic              RVALID_S0,  RVALID_S1;
  logic              RREADY_S0,  RREADY_S1;

  logic [31:0]       ROM_out;
  logic              ROM_enable;
  logic              ROM_read;
  logic [ROM_AW-1:0] ROM_address;

  modport slave (
    input  ARID_S0, ARID_S1, ARADDR_S0, ARADDR_S1, ARLEN_S0, ARLEN_S1,
    input  ARSIZE_S0, ARSIZE_S1, ARBURST_S0, ARBURST_S1, ARVALID_S0, ARVALID_S1,
    output ARREADY_S0, ARREADY_S1,
    output RID_S0, RID_S1, RDATA_S0, RDATA_S1, RRESP_S0, RRESP_S1,
    output RLAST_S0, RLAST_S1, RVALID_S0, RVALID_S1,
    input  RREADY_S0, RREADY_S1,
    input  ROM_out,
    output ROM_enable, ROM_read, ROM_address
  );

  modport master (
    output ARID_S0, ARID_S1, ARADDR_S0, ARADDR_S1, ARLEN_S0, ARLEN_S1,
    output ARSIZE_S0, ARSIZE_S1, ARBURST_S0, ARBURST_S1, ARVALID_S0, ARVALID_S1,
    input  ARREADY_S0, ARREADY_S1,
    input  RID_S0, RID_S1, RDATA_S0, RDATA_S1, RRESP_S0, RRESP_S1,
    input  RLAST_S0, RLAST_S1, RVALID_S0, RVALID_S1,
    output RREADY_S0, RREADY_S1,
    output ROM_out,
    input  ROM_enable, ROM_read, ROM_address
  );

endinterface

// File: rtl/rom_read_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the owner when its burst completes.
// Grant is combinational from req; the pointer only matters when both request.
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  owner_t     upd_owner_i,
  output logic [1:0] grant_o
);

  owner_t ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (ptr_q == S1) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = flip_owner(upd_owner_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= S0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one single-port ROM between two AXI read requesters, one beat in flight, 2 cycles per beat.
// Optional ROM_ARB_DECERR_EN: out-of-range ARADDR returns DECERR beats without touching the ROM.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_AW = ROM_AW_DEF,
  parameter int IDW    = IDW_DEF,
  parameter int LENW   = LENW_DEF
)
(
  input  logic               clk,
  input  logic               rst,
  rom_read_arbiter_if.slave  bus
);

  state_t            state_q,  state_d;
  owner_t            owner_q,  owner_d;
  logic [IDW-1:0]    id_q,     id_d;
  logic [ROM_AW-1:0] addr_q,   addr_d;
  logic [LENW-1:0]   limit_q,  limit_d;
  logic [LENW-1:0]   cnt_q,    cnt_d;
  logic              decerr_q, decerr_d;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              win_s1;
  logic [IDW-1:0]    ar_id;
  logic [31:0]       ar_addr;
  logic [LENW-1:0]   ar_len;
  logic              owner_rready;
  logic              beat_hs;
  logic              last_beat;
  logic              burst_done;
  logic              in_data;
  logic [31:0]       rdat;
  logic [1:0]        rresp;

  // Requests are only visible in IDLE and never while reset is asserted.
  assign req = {bus.ARVALID_S1, bus.ARVALID_S0} & {2{(state_q == IDLE) && !rst}};

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .upd_i       (burst_done),
    .upd_owner_i (owner_q),
    .grant_o     (grant)
  );

  assign win_s1  = grant[1];
  assign ar_id   = win_s1 ? bus.ARID_S1   : bus.ARID_S0;
  assign ar_addr = win_s1 ? bus.ARADDR_S1 : bus.ARADDR_S0;
  assign ar_len  = win_s1 ? bus.ARLEN_S1  : bus.ARLEN_S0;

  assign owner_rready = (owner_q == S1) ? bus.RREADY_S1 : bus.RREADY_S0;
  assign in_data      = (state_q == DATA);
  assign beat_hs      = in_data && owner_rready;
  assign last_beat    = (cnt_q == limit_q);
  assign burst_done   = beat_hs && last_beat;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    id_d     = id_q;
    addr_d   = addr_q;
    limit_d  = limit_q;
    cnt_d    = cnt_q;
    decerr_d = decerr_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          owner_d = win_s1 ? S1 : S0;
          id_d    = ar_id;
          addr_d  = ar_addr[ROM_AW+1:2];
          limit_d = ar_len;
          cnt_d   = '0;
`ifdef ROM_ARB_DECERR_EN
          decerr_d = |ar_addr[31:ROM_AW+2];
`else
          decerr_d = 1'b0;
`endif
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = DATA;
      end
      DATA: begin
        if (beat_hs) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= S0;
      id_q     <= '0;
      addr_q   <= '0;
      limit_q  <= '0;
      cnt_q    <= '0;
      decerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      limit_q  <= limit_d;
      cnt_q    <= cnt_d;
      decerr_q <= decerr_d;
    end
  end

  // ROM pins stay asserted through DATA so ROM_out is re-read at the same address during a stall.
  always_comb begin
    bus.ROM_enable  = (state_q != IDLE) && !decerr_q;
    bus.ROM_read    = (state_q != IDLE) && !decerr_q;
    bus.ROM_address = (state_q != IDLE) ? addr_q : '0;
  end

  assign rdat  = decerr_q ? 32'h0 : bus.ROM_out;
  assign rresp = decerr_q ? RESP_DECERR : RESP_OKAY;

  always_comb begin
    bus.ARREADY_S0 = grant[0];
    bus.ARREADY_S1 = grant[1];

    bus.RVALID_S0  = in_data && (owner_q == S0);
    bus.RLAST_S0   = bus.RVALID_S0 && last_beat;
    bus.RDATA_S0   = bus.RVALID_S0 ? rdat  : 32'h0;
    bus.RID_S0     = bus.RVALID_S0 ? id_q  : '0;
    bus.RRESP_S0   = bus.RVALID_S0 ? rresp : RESP_OKAY;

    bus.RVALID_S1  = in_data && (owner_q == S1);
    bus.RLAST_S1   = bus.RVALID_S1 && last_beat;
    bus.RDATA_S1   = bus.RVALID_S1 ? rdat  : 32'h0;
    bus.RID_S1     = bus.RVALID_S1 ? id_q  : '0;
    bus.RRESP_S1   = bus.RVALID_S1 ? rresp : RESP_OKAY;
  end

  // Size and burst type are fixed to word INCR; byte-lane bits are don't-care.
  logic unused_ok;
  assign unused_ok = ^{bus.ARSIZE_S0, bus.ARSIZE_S1, bus.ARBURST_S0, bus.ARBURST_S1,
                       bus.ARADDR_S0, bus.ARADDR_S1};

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: vector table of single bursts plus arbitration and reset sequences.
module tb_rom_read_arbiter;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rom_read_arbiter_if #(.ROM_AW(12), .IDW(8), .LENW(4)) bus ();

  rom_read_arbiter #(.ROM_AW(12), .IDW(8), .LENW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {8'hC3, a, ~a};
  endfunction

  // ROM macro model: data appears the cycle after enable/address are sampled.
  always @(posedge clk) begin
    if (bus.ROM_enable && bus.ROM_read) bus.ROM_out <= rom_word(bus.ROM_address);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rvalid(input int p);
    return p ? bus.RVALID_S1 : bus.RVALID_S0;
  endfunction
  function automatic logic rlast(input int p);
    return p ? bus.RLAST_S1 : bus.RLAST_S0;
  endfunction
  function automatic logic [31:0] rdata(input int p);
    return p ? bus.RDATA_S1 : bus.RDATA_S0;
  endfunction
  function automatic logic [7:0] rid(input int p);
    return p ? bus.RID_S1 : bus.RID_S0;
  endfunction
  function automatic logic [1:0] rresp(input int p);
    return p ? bus.RRESP_S1 : bus.RRESP_S0;
  endfunction
  function automatic logic arready(input int p);
    return p ? bus.ARREADY_S1 : bus.ARREADY_S0;
  endfunction

  task automatic set_ar(input int p, input logic v, input logic [7:0] id,
                        input logic [31:0] addr, input logic [3:0] len);
    if (p == 1) begin
      bus.ARVALID_S1 = v; bus.ARID_S1 = id; bus.ARADDR_S1 = addr; bus.ARLEN_S1 = len;
    end else begin
      bus.ARVALID_S0 = v; bus.ARID_S0 = id; bus.ARADDR_S0 = addr; bus.ARLEN_S0 = len;
    end
  endtask

  task automatic set_rready(input int p, input logic v);
    if (p == 1) bus.RREADY_S1 = v;
    else        bus.RREADY_S0 = v;
  endtask

  task automatic clr_arvalid(input int p);
    if (p == 1) bus.ARVALID_S1 = 1'b0;
    else        bus.ARVALID_S0 = 1'b0;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 in the FETCH cycle.
  task automatic ar(input int p, input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    set_ar(p, 1'b1, id, addr, len);
    #1;
    chk("ar_ready", 32'(arready(p)), 32'd1);
    @(posedge clk); #1;
    clr_arvalid(p);
  endtask

  // Starts in the FETCH cycle after the AR handshake; ends at posedge+1 after the last beat.
  task automatic data_phase(input int p, input logic [7:0] id, input logic [3:0] len,
                            input logic [11:0] wa0, input logic [1:0] resp,
                            input int stall_beat, input int stall_cyc);
    logic [11:0] wa;
    logic [31:0] exp_d;
    for (int b = 0; b <= int'(len); b++) begin
      wa    = wa0 + 12'(b);
      exp_d = (resp == OKAY) ? rom_word(wa) : 32'h0;
      chk("fetch_rvalid", 32'(rvalid(p)), 32'd0);
      chk("fetch_rom_en", 32'(bus.ROM_enable), 32'(resp == OKAY));
      if (resp == OKAY) chk("fetch_addr", 32'(bus.ROM_address), 32'(wa));
      @(posedge clk); #1;
      chk("rvalid",  32'(rvalid(p)), 32'd1);
      chk("rdata",   rdata(p), exp_d);
      chk("rid",     32'(rid(p)), 32'(id));
      chk("rresp",   32'(rresp(p)), 32'(resp));
      chk("rlast",   32'(rlast(p)), 32'(b == int'(len)));
      chk("other_rvalid",  32'(rvalid(1 - p)), 32'd0);
      chk("other_arready", 32'(arready(1 - p)), 32'd0);
      chk("own_arready",   32'(arready(p)), 32'd0);
      chk("data_rom_en",   32'(bus.ROM_enable), 32'(resp == OKAY));
      if (b == stall_beat) begin
        set_rready(p, 1'b0);
        for (int c = 0; c < stall_cyc; c++) begin
          @(posedge clk); #1;
          chk("stall_rvalid", 32'(rvalid(p)), 32'd1);
          chk("stall_rdata",  rdata(p), exp_d);
          chk("stall_addr",   32'(bus.ROM_address), 32'(wa));
        end
        set_rready(p, 1'b1);
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int          port;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [11:0] wa;
    logic [1:0]  resp;
    int          stall_beat;
    int          stall_cyc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 8'h11, 32'h0000_0010, 4'd0,  12'h004, OKAY, -1, 0};
    vecs[1] = '{1, 8'h22, 32'h0000_3FF8, 4'd3,  12'hFFE, OKAY, -1, 0};
    vecs[2] = '{0, 8'h33, 32'h0000_0100, 4'd1,  12'h040, OKAY, -1, 0};
`ifdef ROM_ARB_DECERR_EN
    vecs[3] = '{1, 8'h44, 32'h0001_0000, 4'd1,  12'h000, DECERR, -1, 0};
`else
    vecs[3] = '{1, 8'h44, 32'h0001_0000, 4'd1,  12'h000, OKAY, -1, 0};
`endif
    vecs[4] = '{0, 8'h55, 32'h0000_0020, 4'd15, 12'h008, OKAY, 2, 5};

    set_ar(0, 1'b1, 8'h0, 32'h0, 4'd0);
    set_ar(1, 1'b0, 8'h0, 32'h0, 4'd0);
    bus.ARSIZE_S0 = 3'd2;    bus.ARSIZE_S1 = 3'd2;
    bus.ARBURST_S0 = 2'b01;  bus.ARBURST_S1 = 2'b01;
    bus.RREADY_S0 = 1'b1;    bus.RREADY_S1 = 1'b1;

    // Reset values, with a request pending that must not be accepted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready_s0", 32'(bus.ARREADY_S0), 32'd0);
    chk("rst_arready_s1", 32'(bus.ARREADY_S1), 32'd0);
    chk("rst_rvalid_s0",  32'(bus.RVALID_S0), 32'd0);
    chk("rst_rvalid_s1",  32'(bus.RVALID_S1), 32'd0);
    chk("rst_rlast_s0",   32'(bus.RLAST_S0), 32'd0);
    chk("rst_rdata_s0",   bus.RDATA_S0, 32'h0);
    chk("rst_rid_s1",     32'(bus.RID_S1), 32'd0);
    chk("rst_rresp_s0",   32'(bus.RRESP_S0), 32'(OKAY));
    chk("rst_rom_en",     32'(bus.ROM_enable), 32'd0);
    chk("rst_rom_rd",     32'(bus.ROM_read), 32'd0);
    chk("rst_rom_addr",   32'(bus.ROM_address), 32'd0);
    clr_arvalid(0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_rom_en", 32'(bus.ROM_enable), 32'd0);

    // Simultaneous requests after reset: S0 first, then S1, then S0 again.
    set_ar(0, 1'b1, 8'hA0, 32'h0000_0200, 4'd1);
    set_ar(1, 1'b1, 8'hB0, 32'h0000_0300, 4'd0);
    #1;
    chk("both_first_s0", 32'(bus.ARREADY_S0), 32'd1);
    chk("both_first_s1", 32'(bus.ARREADY_S1), 32'd0);
    @(posedge clk); #1;
    clr_arvalid(0);
    data_phase(0, 8'hA0, 4'd1, 12'h080, OKAY, -1, 0);
    chk("s1_after_s0", 32'(bus.ARREADY_S1), 32'd1);
    @(posedge clk); #1;
    clr_arvalid(1);
    data_phase(1, 8'hB0, 4'd0, 12'h0C0, OKAY, -1, 0);
    set_ar(0, 1'b1, 8'hA1, 32'h0000_0004, 4'd0);
    set_ar(1, 1'b1, 8'hB1, 32'h0000_0008, 4'd0);
    #1;
    chk("both_second_s0", 32'(bus.ARREADY_S0), 32'd1);
    chk("both_second_s1", 32'(bus.ARREADY_S1), 32'd0);
    @(posedge clk); #1;
    clr_arvalid(0);
    data_phase(0, 8'hA1, 4'd0, 12'h001, OKAY, -1, 0);
    chk("s1_granted", 32'(bus.ARREADY_S1), 32'd1);
    @(posedge clk); #1;
    clr_arvalid(1);
    data_phase(1, 8'hB1, 4'd0, 12'h002, OKAY, -1, 0);

    // Table of single bursts.
    for (int i = 0; i < 5; i++) begin
      ar(vecs[i].port, vecs[i].id, vecs[i].addr, vecs[i].len);
      data_phase(vecs[i].port, vecs[i].id, vecs[i].len, vecs[i].wa, vecs[i].resp,
                 vecs[i].stall_beat, vecs[i].stall_cyc);
    end

    // Reset during beat 2 of a 4-beat burst, then a fresh burst.
    ar(1, 8'h77, 32'h0000_0000, 4'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_rvalid", 32'(bus.RVALID_S1), 32'd1);
    chk("pre_rst_rdata",  bus.RDATA_S1, rom_word(12'h001));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rvalid", 32'(bus.RVALID_S1), 32'd0);
    chk("mid_rst_rlast",  32'(bus.RLAST_S1), 32'd0);
    chk("mid_rst_rdata",  bus.RDATA_S1, 32'h0);
    chk("mid_rst_rid",    32'(bus.RID_S1), 32'd0);
    chk("mid_rst_rom_en", 32'(bus.ROM_enable), 32'd0);
    chk("mid_rst_rom_rd", 32'(bus.ROM_read), 32'd0);
    chk("mid_rst_addr",   32'(bus.ROM_address), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    ar(1, 8'h78, 32'h0000_0040, 4'd0);
    data_phase(1, 8'h78, 4'd0, 12'h010, OKAY, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one single-port ROM macro between two AXI read-only requesters: S0 = instruction fetch, S1 = data/DMA.
- Sits between the AXI crossbar slave side and the ROM macro, in place of a dedicated per-master ROM wrapper.
- Round-robin arbitration at burst granularity. INCR bursts of 1-16 beats; one beat in flight at a time.

Parameters:
- ROM_AW, 12, ROM word-address width. ROM_address = ARADDR[ROM_AW+1:2].
- IDW, `AXI_IDS_BITS, ID width on both slave ports.
- LENW, `AXI_LEN_BITS (4), burst-length field width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ARID_S0/S1  in  IDW  read address ID
- ARADDR_S0/S1  in  32  byte address, word aligned
- ARLEN_S0/S1  in  LENW  beats-1
- ARSIZE_S0/S1  in  3  ignored; always word
- ARBURST_S0/S1  in  2  ignored; always treated as INCR
- ARVALID_S0/S1  in  1  address valid
- ARREADY_S0/S1  out  1  address accept
- RID_S0/S1  out  IDW  returned ID
- RDATA_S0/S1  out  32  read data
- RRESP_S0/S1  out  2  response
- RLAST_S0/S1  out  1  final beat
- RVALID_S0/S1  out  1  data valid
- RREADY_S0/S1  in  1  master ready
- ROM_out  in  32  ROM data, valid the cycle after address/enable are sampled
- ROM_enable  out  1  ROM chip enable
- ROM_read  out  1  ROM read strobe
- ROM_address  out  ROM_AW  ROM word address

Behaviour:
- Reset values:
  - All ARREADY_Sx = 0, RVALID_Sx = 0, RLAST_Sx = 0, RID_Sx = 0, RDATA_Sx = 0, RRESP_Sx = OKAY.
  - ROM_enable = 0, ROM_read = 0, ROM_address = 0.
  - State = IDLE; priority pointer = S0.
- FSM states: IDLE, FETCH, DATA.
- IDLE:
  - Winner = the sole ARVALID port; if both are valid, the port named by the priority pointer.
  - ARREADY of the winner is combinational and high only in IDLE. The loser's ARREADY = 0.
  - On handshake: latch owner, ARID, ARADDR[ROM_AW+1:2] into the address register, ARLEN into the beat counter limit. Clear beat count. Go to FETCH.
- FETCH (1 cycle):
  - ROM_enable = ROM_read = 1, ROM_address = address register.
  - Go to DATA.
- DATA:
  - ROM_enable/ROM_read/ROM_address held so ROM_out stays stable.
  - RVALID_owner = 1. RDATA_owner = ROM_out. RID_owner = latched ID. RRESP = OKAY. RLAST_owner = (beat count == limit).
  - Stall: RVALID and RDATA stay stable until RREADY_owner.
  - Handshake, not last: address+1 (wraps modulo 2^ROM_AW), beat count+1, go to FETCH.
  - Handshake, last: go to IDLE; priority pointer = the other port.
- Latency: AR handshake to first RVALID = 2 cycles. Beat-to-beat = 2 cycles with RREADY held high.
- Non-owner port: RVALID = RLAST = 0, RDATA = 0, RID = 0, ARREADY = 0 while busy.
- No ARVALID in IDLE: ROM_enable = ROM_read = 0; the pointer is unchanged.
- A new ARVALID from the owner during its own burst is not accepted until IDLE.
- rst mid-burst: abort immediately to reset values; the burst is lost, no RLAST is issued.

Optional Feature:
- Macro: ROM_ARB_DECERR_EN.
- Defined:
  - An AR with ARADDR[31:ROM_AW+2] != 0 is still accepted.
  - Goes to DATA without ROM access: ROM_enable stays 0.
  - Every beat returns RDATA = 0, RRESP = `AXI_RESP_DECERR, normal RLAST.
  - Beats are spaced as normal; the FETCH cycle is kept, but ROM is not enabled.
- Undefined: upper address bits are ignored, the address aliases into the ROM, and RRESP = OKAY.

Decomposition:
- Package rom_arb_pkg: state enum (IDLE, FETCH, DATA), owner typedef (S0/S1), ROM_AW default.
- AXI response/width constants come from AXI_define.svh.
- Sub-module rr_arb2:
  - Inputs: req[1:0], pointer, update.
  - Output: one-hot grant.
  - Pointer register inside; updates on burst completion.

Test Plan:
- Single S0 read, ARADDR=0x10, ARLEN=0, RREADY=1 -> ROM_address=4; RVALID_S0 2 cycles after AR; RDATA=ROM[4]; RLAST=1; RID echoes ARID.
- S1 burst ARADDR=0x3FF8, ARLEN=3 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 (wrap); 4 beats; RLAST only on the 4th.
- Both ARVALID in the same cycle after reset -> S0 granted first; S1 granted right after S0's RLAST; the next simultaneous request goes to S0.
- RREADY_S0 low 5 cycles mid-burst -> RVALID/RDATA/ROM_address held; no beat skipped or repeated.
- rst asserted during beat 2 of a 4-beat burst -> next cycle all outputs at reset values; a fresh request completes normally.
- With ROM_ARB_DECERR_EN, ARADDR=0x0001_0000, ARLEN=1 -> 2 beats RRESP=DECERR, RDATA=0, ROM_enable never 1. Without the macro -> aliased ROM[0], ROM[1], RRESP=OKAY.
